// File: rtl/cim_pkg.sv
// Shared encodings for the compute-in-memory ternary datapath.
package cim_pkg;

  typedef enum logic [1:0] {
    WGT_ZERO = 2'b00,
    WGT_POS  = 2'b01,
    WGT_RSVD = 2'b10,
    WGT_NEG  = 2'b11
  } wgt_e;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10
  } op_e;

  function automatic op_e wgt_to_op(input logic [1:0] wgt);
    case (wgt)
      WGT_POS: wgt_to_op = OP_ADD;
      WGT_NEG: wgt_to_op = OP_SUB;
      default: wgt_to_op = OP_PASS;
    endcase
  endfunction

endpackage

// File: rtl/ternary_accumulator_sat_addsub.sv
// Combinational saturating add/subtract of a sign-extended narrow operand.
module sat_addsub
  import cim_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic signed [ACC_W-1:0]  i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  op_e                      i_op,
  output logic signed [ACC_W-1:0]  o_result,
  output logic                     o_overflow
);

  logic signed [ACC_W:0] w_a;
  logic signed [ACC_W:0] w_b;
  logic signed [ACC_W:0] w_sum;

  // One guard bit: extending before negation keeps -(-2^(DATA_W-1)) exact.
  always_comb begin
    w_a   = {i_a[ACC_W-1], i_a};
    w_b   = {{(ACC_W + 1 - DATA_W){i_b[DATA_W-1]}}, i_b};
    w_sum = w_a;
    case (i_op)
      OP_ADD:  w_sum = w_a + w_b;
      OP_SUB:  w_sum = w_a - w_b;
      default: w_sum = w_a;
    endcase
    o_overflow = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    o_result   = w_sum[ACC_W-1:0];
    if (o_overflow) begin
      o_result = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ternary_accumulator.sv
// Ternary-weight dot-product accumulator with saturation and a held result.
module ternary_accumulator
  import cim_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_act,
  input  logic [1:0]               in_wgt,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_sat
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_e                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sat;

  logic signed [ACC_W-1:0] w_sum;
  logic                    w_ovf;
  logic                    w_cnt_last;
  logic                    w_accept;

  assign w_cnt_last = (r_cnt == CNT_W'(LEN - 1));
  assign w_accept   = in_valid && (r_state == ST_ACCUM);

  sat_addsub #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_addsub (
    .i_a        (r_acc),
    .i_b        (in_act),
    .i_op       (wgt_to_op(in_wgt)),
    .o_result   (w_sum),
    .o_overflow (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_sat <= r_sat | w_ovf;
            // The final beat leaves the counter alone so it never wraps past LEN-1.
            if (in_last || w_cnt_last) begin
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_acc;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_ternary_accumulator.sv
// Scoreboard bench: two instances (ACC_W=16 and ACC_W=9) share one stimulus stream.
module tb_ternary_accumulator;

  localparam int DW  = 8;
  localparam int LEN = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] in_act = '0;
  logic [1:0]           in_wgt = '0;

  logic                 rdy16, rdy9, ov16, ov9, sat16, sat9;
  logic signed [15:0]   d16;
  logic signed [8:0]    d9;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int e16;
    bit s16;
    int e9;
    bit s9;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  ternary_accumulator #(.DATA_W(DW), .ACC_W(16), .LEN(LEN)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy16),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .in_last   (in_last),
    .out_valid (ov16),
    .out_ready (out_ready),
    .out_data  (d16),
    .out_sat   (sat16)
  );

  ternary_accumulator #(.DATA_W(DW), .ACC_W(9), .LEN(LEN)) u_dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy9),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .in_last   (in_last),
    .out_valid (ov9),
    .out_ready (out_ready),
    .out_data  (d9),
    .out_sat   (sat9)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int e16, input bit s16, input int e9, input bit s9);
    exp_t e;
    e.e16 = e16; e.s16 = s16; e.e9 = e9; e.s9 = s9;
    q.push_back(e);
  endtask

  // Monitor: compares on every cycle where an output handshake will occur.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_ready && ov16) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected no result", d16);
      end else begin
        e = q.pop_front();
        chk("res_data16", int'(d16), e.e16);
        chk("res_sat16", int'(sat16), int'(e.s16));
        chk("res_data9", int'(d9), e.e9);
        chk("res_sat9", int'(sat9), int'(e.s9));
        chk("res_valid9", int'(ov9), 1);
      end
    end
  end

  task automatic send(input int a, input logic [1:0] w, input logic l, input bit fin);
    in_valid = 1'b1;
    in_act   = DW'(a);
    in_wgt   = w;
    in_last  = l;
    if (fin) chk("pre_final_valid", int'(ov16), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_act   = '0;
    in_wgt   = '0;
    if (fin) begin
      chk("latency_valid16", int'(ov16), 1);
      chk("latency_valid9", int'(ov9), 1);
      chk("hold_in_ready", int'(rdy16), 0);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_act   = 8'sd99;
      in_wgt   = 2'b01;
      in_last  = 1'b1;
      @(posedge clk); #1;
    end
    in_act  = '0;
    in_wgt  = '0;
    in_last = 1'b0;
  endtask

  // Hold the result under backpressure (while also offering ignored beats), then release.
  task automatic drain(input int hold);
    logic signed [15:0] snap16;
    logic signed [8:0]  snap9;
    snap16 = d16;
    snap9  = d9;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_act   = 8'sd50;
      in_wgt   = 2'b01;
      in_last  = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready", int'(rdy16), 0);
      chk("bp_out_valid", int'(ov16), 1);
      chk("bp_data16", int'(d16), int'(snap16));
      chk("bp_data9", int'(d9), int'(snap9));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_act    = '0;
    in_wgt    = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", int'(ov16), 0);
    chk("post_hs_ready16", int'(rdy16), 1);
    chk("post_hs_ready9", int'(rdy9), 1);
    chk("post_hs_data", int'(d16), 0);
  endtask

  task automatic check_reset();
    chk("rst_ready16", int'(rdy16), 1);
    chk("rst_valid16", int'(ov16), 0);
    chk("rst_data16", int'(d16), 0);
    chk("rst_sat16", int'(sat16), 0);
    chk("rst_ready9", int'(rdy9), 1);
    chk("rst_valid9", int'(ov9), 0);
    chk("rst_data9", int'(d9), 0);
    chk("rst_sat9", int'(sat9), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_ignored_in_accum", int'(ov16), 0);

    // Basic sum with backpressure and ignored beats while holding.
    push(12, 0, 12, 0);
    send(10, 2'b01, 0, 0);
    send(3,  2'b11, 0, 0);
    send(7,  2'b00, 0, 0);
    send(5,  2'b01, 1, 1);
    drain(5);

    // Early last with most-negative activation negated.
    push(256, 0, 255, 1);
    send(-128, 2'b11, 0, 0);
    send(-128, 2'b11, 1, 1);
    drain(0);

    // Positive saturation on the narrow instance.
    push(381, 0, 255, 1);
    send(127, 2'b01, 0, 0);
    send(127, 2'b01, 0, 0);
    send(127, 2'b01, 1, 1);
    drain(0);

    // Sticky flag cleared for the next vector.
    push(1, 0, 1, 0);
    send(1, 2'b01, 1, 1);
    drain(0);

    // Vector ended by the LEN limit.
    push(38, 0, 38, 0);
    send(100, 2'b01, 0, 0);
    send(-50, 2'b01, 0, 0);
    send(20,  2'b11, 0, 0);
    send(8,   2'b01, 0, 1);
    drain(1);

    // Stalls and a reserved weight, ended by the LEN limit.
    push(10, 0, 10, 0);
    send(5, 2'b01, 0, 0);
    gap(2);
    send(9, 2'b10, 0, 0);
    gap(1);
    send(-3, 2'b11, 0, 0);
    send(2,  2'b01, 0, 1);
    drain(0);

    // Negative saturation on the narrow instance.
    push(-384, 0, -256, 1);
    send(-128, 2'b01, 0, 0);
    send(-128, 2'b01, 0, 0);
    send(-128, 2'b01, 1, 1);
    drain(0);

    // Reset mid-vector discards the partial sum.
    send(50, 2'b01, 0, 0);
    send(50, 2'b01, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(7, 0, 7, 0);
    send(7, 2'b01, 1, 1);
    drain(0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ternary_accumulator.md
TERNARY_ACCUMULATOR -- requirements
Module: ternary_accumulator

Interface
REQ-001 Parameter DATA_W, default 8, signed activation width.
REQ-002 Parameter ACC_W, default 16, signed accumulator/result width; SHALL be > DATA_W.
REQ-003 Parameter LEN, default 64, maximum beats per dot product; counter width $clog2(LEN).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  activation/weight beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 in_act  input  DATA_W  signed two's-complement activation.
REQ-009 in_wgt  input  2  ternary weight: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0, 2'b10 = reserved (treated as 0).
REQ-010 in_last  input  1  marks the final beat of a vector; qualified by in_valid.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  ACC_W  signed accumulated result.
REQ-014 out_sat  output  1  result was clamped at least once during this vector.

Function
REQ-015 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 Input handshake: a beat is accepted on a rising edge with in_valid && in_ready; in_act, in_wgt, and in_last SHALL be ignored otherwise.
REQ-017 Per accepted beat: weight +1 adds sign-extended in_act; weight -1 subtracts it; weight 0 or reserved leaves acc unchanged, but the beat still counts.
REQ-018 Sign extension to ACC_W SHALL precede negation, so in_act = -2^(DATA_W-1) with weight -1 yields +2^(DATA_W-1) exactly.
REQ-019 Arithmetic SHALL saturate: a result above 2^(ACC_W-1)-1 clamps to max, and a result below -2^(ACC_W-1) clamps to min.
REQ-020 Any clamp SHALL set a sticky sat flag for the current vector.
REQ-021 The beat counter SHALL increment per accepted beat.
REQ-022 The vector SHALL end on an accepted beat with in_last=1 or with counter==LEN-1, whichever comes first.
REQ-023 On vector end: the update including that beat SHALL be written; the state SHALL move to HOLD the next cycle; out_valid SHALL rise one cycle after the final beat is accepted (latency 1).
REQ-024 In HOLD, out_data and out_sat SHALL remain stable until out_valid && out_ready.
REQ-025 On the output handshake: acc, counter, and sat SHALL clear to 0; the state SHALL return to ACCUM; in_ready SHALL rise the next cycle; no bypass.
REQ-026 in_last is a don't-care when the LEN limit ends the vector.
REQ-027 Counter wrap beyond LEN-1 SHALL be impossible.
REQ-028 out_ready asserted in ACCUM SHALL have no effect.
REQ-029 A zero-length vector is not possible; a vector holds a minimum of 1 beat.

Reset
REQ-030 When rst_n=0, asynchronously: state=ACCUM, acc=0, counter=0, sat=0.
REQ-031 Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0.
REQ-032 Reset mid-vector or in HOLD SHALL discard the partial or pending result with no output.
REQ-033 Deassertion SHALL be synchronised externally; the block accepts a beat on the first clock edge after deassertion.

Structure
REQ-034 Shared package cim_pkg SHALL hold the ternary weight encodings (WGT_POS, WGT_NEG, WGT_ZERO) and the FSM state encoding (ST_ACCUM, ST_HOLD).
REQ-035 One combinational sub-module, sat_addsub, SHALL be instantiated.
REQ-036 sat_addsub ports: (ACC_W operand a, DATA_W operand b, op add/sub/pass) -> (ACC_W result, overflow flag).
REQ-037 The FSM, counter, and registers SHALL live in ternary_accumulator.

Verification
REQ-038 Basic sum (LEN=4, DATA_W=8, ACC_W=16): beats (10,+1),(3,-1),(7,0),(5,+1 last) -> out_data=12, out_sat=0; out_valid rises one cycle after the last beat.
REQ-039 Early in_last: 2 beats (-128,-1),(-128,-1 last) -> out_data=256, out_sat=0; the next vector starts from 0.
REQ-040 Saturation (ACC_W=9): beats (127,+1)x3 -> out_data=255, out_sat=1; a following vector with (1,+1 last) -> out_data=1, out_sat=0.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> in_ready=0 and out_data stable throughout; the handshake is accepted on the first cycle with out_ready=1.
REQ-042 Stalls and reserved codes: gaps in in_valid plus reserved weight 2'b10 mid-vector -> result is unaffected and the beat count is respected.
REQ-043 Reset mid-vector: assert rst_n=0 after 2 beats -> all outputs return to reset values immediately; a fresh vector after release gives the correct sum with no residue.
